// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one 4-bit lookahead nibble per clock.
// Borrow ripples LSB-first through a register between nibbles.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic [IW-1:0]    idx_q;
  logic             brw_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;
  logic             zero_q;
  logic             ovf_q;

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s;
  logic       last;

  always_comb begin
    x = a_q[{idx_q, 2'b00} +: 4];
    y = ~b_q[{idx_q, 2'b00} +: 4];
    g = x & y;
    p = x ^ y;
    c[0] = ~brw_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s = p ^ c[3:0];
    d_d = d_q;
    d_d[{idx_q, 2'b00} +: 4] = s;
    last = (idx_q == IW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      brw_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          d_q   <= d_d;
          brw_q <= ~c[4];
          idx_q <= idx_q + IW'(1);
          if (last) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            borrow_q <= ~c[4];
            zero_q   <= (d_d == '0);
            ovf_q    <= (a_q[MSB] != b_q[MSB]) && (d_d[MSB] != a_q[MSB]);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          // back-to-back request skips IDLE
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign d      = d_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor.
// Covers WIDTH=16 vectors, back-to-back, ignored start, reset and WIDTH=4.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        borrow;
  logic        zero;
  logic        ovf;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [3:0]  d4;
  logic        borrow4;
  logic        zero4;
  logic        ovf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow(borrow),
    .zero(zero), .ovf(ovf)
  );

  nibble_serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .borrow(borrow4),
    .zero(zero4), .ovf(ovf4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start an op at the current cycle; return edges until done (0 = timeout)
  task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                       output int lat);
    start = 1'b1;
    a = av;
    b = bv;
    tick();
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    chk("busy_after_start", busy, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;
    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0100, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_flags", {borrow, zero, ovf}, 0);
    chk("rst_d4", {busy4, done4, d4, borrow4, zero4, ovf4}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run16(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_d", i), d, vecs[i].d);
      chk($sformatf("v%0d_borrow", i), borrow, vecs[i].borrow);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].zero);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d_busy_done", i), busy, 0);
      tick();
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_d_hold", i), d, vecs[i].d);
      chk($sformatf("v%0d_flag_hold", i), {borrow, zero, ovf},
          {vecs[i].borrow, vecs[i].zero, vecs[i].ovf});
    end

    // back-to-back: start held in DONE
    run16(16'hA5A5, 16'hA5A5, lat);
    chk("b2b_first_zero", zero, 1);
    start = 1'b1;
    a = 16'h0005;
    b = 16'h0003;
    tick();
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    chk("b2b_done_low", done, 0);
    chk("b2b_busy", busy, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("b2b_latency", lat, 4);
    chk("b2b_d", d, 16'h0002);
    chk("b2b_flags", {borrow, zero, ovf}, 0);
    tick();
    tick();

    // start during RUN is ignored
    start = 1'b1;
    a = 16'h1234;
    b = 16'h0234;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'h0000;
    tick();
    start = 1'b0;
    pulses = 0;
    lat = 0;
    for (int i = 4; i <= 12; i++) begin
      if (done) begin
        pulses++;
        if (lat == 0) lat = i - 1;
        chk("ign_d", d, 16'h1000);
      end
      tick();
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_latency", lat, 4);

    // reset mid-RUN at idx=2
    start = 1'b1;
    a = 16'h0000;
    b = 16'h0001;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rstrun_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_d", d, 0);
    chk("rstrun_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    chk("rstrun_no_done", pulses, 0);
    run16(16'h1234, 16'h0234, lat);
    chk("rstrun_fresh_lat", lat, 4);
    chk("rstrun_fresh_d", d, 16'h1000);
    tick();

    // WIDTH=4: 4 - 9
    start4 = 1'b1;
    a4 = 4'h4;
    b4 = 4'h9;
    tick();
    start4 = 1'b0;
    a4 = 4'hF;
    b4 = 4'h0;
    chk("w4_busy", busy4, 1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done4) begin
        lat = i;
        break;
      end
    end
    chk("w4_latency", lat, 1);
    chk("w4_d", d4, 4'hB);
    chk("w4_borrow", borrow4, 1);
    chk("w4_zero", zero4, 0);
    chk("w4_ovf", ovf4, 1);
    tick();
    chk("w4_done_pulse", done4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
